// File: rtl/axi_lite_master_arbiter.sv
// Round-robin share of one AXI4-Lite master port among NUM_REQ requesters, one transaction in flight.
// Latency: grant T, AW/W or AR at T+1, B/R at T+2, rsp_valid at T+3; AXI valids and payload held until ready.
module axi_lite_master_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  input  logic [NUM_REQ*4-1:0]  req_wstrb,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [31:0]           awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [31:0]           araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   rr_ptr, gnt, pick, pick_nxt;
  logic            found;
  logic [31:0]     addr_q, wdata_q, rdata_q;
  logic [3:0]      wstrb_q;
  logic [1:0]      resp_q;
  logic            aw_done, w_done;

  // Rotating priority scan starting at rr_ptr.
  always_comb begin
    int            idx;
    logic [GW-1:0] idx_g;
    idx      = 0;
    idx_g    = '0;
    found    = 1'b0;
    pick     = '0;
    pick_nxt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_g = GW'(idx);
      if (!found && req_valid[idx_g]) begin
        found    = 1'b1;
        pick     = idx_g;
        pick_nxt = (idx + 1 == NUM_REQ) ? '0 : GW'(idx + 1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (found) begin
          req_ready = NUM_REQ'(1) << pick;
          state_nxt = req_write[pick] ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ:  if ((aw_done || awready) && (w_done || wready)) state_nxt = WR_RESP;
      WR_RESP: if (bvalid) state_nxt = RESP;
      RD_REQ:  if (arready) state_nxt = RD_DATA;
      RD_DATA: if (rvalid) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rr_ptr  <= '0;
      gnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt     <= pick;
            rr_ptr  <= pick_nxt;
            addr_q  <= req_addr[32*pick +: 32];
            wdata_q <= req_wdata[32*pick +: 32];
            wstrb_q <= req_wstrb[4*pick +: 4];
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        WR_REQ: begin
          if (awready) aw_done <= 1'b1;
          if (wready)  w_done  <= 1'b1;
        end
        WR_RESP: begin
          if (bvalid) begin
            resp_q  <= bresp;
            rdata_q <= '0;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            resp_q  <= rresp;
            rdata_q <= rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Each write channel drops its valid once its own handshake has landed.
  assign awvalid   = (state == WR_REQ) && !aw_done;
  assign wvalid    = (state == WR_REQ) && !w_done;
  assign bready    = (state == WR_RESP);
  assign arvalid   = (state == RD_REQ);
  assign rready    = (state == RD_DATA);
  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign rsp_valid = (state == RESP) ? (NUM_REQ'(1) << gnt) : '0;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

endmodule
